load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Owns the memory side of the load/store path. It accepts one load or store per transaction from the execute stage and drives a simple req/gnt/rvalid data-memory interface. Loads return sign- or zero-extended data on rsp_rdata, which feeds the mem_rd_data input of the register-file write-data mux. Exactly one transaction is in flight; there is no pipelining across transactions.

Parameters:
WIDTH, 32, data and address width; only 32 is supported (elaboration assertion otherwise).
TIMEOUT_CYCLES, 16, cycles spent in REQ or WAIT before abort; used only with LSU_BUS_TIMEOUT_EN.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  execute stage presents a transaction
req_ready  out  1  LSU can accept (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3: LB/LH/LW/LBU/LHU or SB/SH/SW
req_addr  in  WIDTH  byte address
req_wdata  in  WIDTH  store data, LSB-aligned
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  WIDTH  extended load data (0 for stores and errors)
rsp_err  out  1  misaligned, illegal funct3 or timeout; qualified by rsp_valid
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  WIDTH  word address, bits [1:0] = 0
mem_wdata  out  WIDTH  lane-replicated store data
mem_be  out  WIDTH/8  byte enables
mem_gnt  in  1  memory accepts the request
mem_rvalid  in  1  read data valid
mem_rdata  in  WIDTH  read word

Behaviour:
- Reset (asynchronous, any state): state = IDLE. req_ready = 1. All other outputs 0. Any in-flight transaction is dropped, and mem_req falls immediately.
- States: IDLE, REQ, WAIT, RESP (enum lsu_state_t).
- IDLE:
  - The request is accepted when req_valid && req_ready.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or illegal funct3 (load 3/6/7, store 3-7) → RESP with rsp_err=1. No memory access.
  - Otherwise latch addr, funct3, we and wdata → REQ.
- REQ:
  - mem_req=1. mem_addr, mem_we, mem_wdata and mem_be are registered and stable until grant.
  - On mem_gnt: store → RESP; load → WAIT.
  - mem_req is 0 in the cycle after grant.
  - mem_rvalid is ignored in REQ.
- WAIT:
  - On mem_rvalid, select the lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Register the result into rsp_rdata → RESP.
- RESP: rsp_valid=1 for exactly one cycle → IDLE. There is no response backpressure.
- Registered outputs:
  - rsp_rdata/rsp_err hold their value until the next RESP.
  - rsp_valid is 0 outside RESP.
- Store lanes:
  - SB: wdata = 4 copies of byte[7:0], be = 4'b0001 << addr[1:0].
  - SH: wdata = 2 copies of half[15:0], be = 4'b0011 << addr[1:0].
  - SW: be = 4'b1111.
  - Loads: be = 4'b1111, mem_wdata = 0.
- Latency:
  - Load with immediate grant: accept at cycle 0, mem_req at cycle 1, rvalid at cycle 2, rsp_valid at cycle 3.
  - Store with immediate grant: rsp_valid at cycle 2.
  - Error: rsp_valid at cycle 1.
- A new request may be accepted in the cycle after rsp_valid.

Optional Feature:
LSU_BUS_TIMEOUT_EN:
- Defined: a counter clears on entry to REQ and WAIT and increments each cycle in those states.
- When it reaches TIMEOUT_CYCLES without gnt/rvalid: mem_req drops, → RESP with rsp_err=1 and rsp_rdata=0.
- A late mem_rvalid arriving in IDLE is ignored.
- Undefined: no counter; the LSU waits indefinitely.

Decomposition:
- Shared package rv32i_opcodes (next to regfile_load_t) holds:
  - funct3 constants as enum mem_funct3_t (F3_LB=0, F3_LH=1, F3_LW=2, F3_LBU=4, F3_LHU=5; stores use 0/1/2).
  - lsu_state_t.
- Sub-module load_extend (combinational): inputs mem_rdata, addr[1:0], funct3; output is the extended word. It is reusable by a future cache path.

Test Plan:
- LB at 0x1003, mem_rdata=0x80FF_1234, immediate gnt/rvalid → rsp_valid at cycle 3, rsp_rdata=0xFFFF_FF80, rsp_err=0.
- LHU at 0x2002, mem_rdata=0x9ABC_0000 → rsp_rdata=0x0000_9ABC; mem_addr=0x2000, mem_be=4'hF.
- SB at 0x3001, wdata=0x1234_56A5, gnt delayed 3 cycles → mem_req high 4 cycles with stable mem_wdata=0xA5A5_A5A5, mem_be=4'b0010; rsp_valid 1 cycle after the gnt cycle.
- LW at 0x4002 → rsp_valid at cycle 1, rsp_err=1, mem_req never asserted; LW with funct3=3 → same.
- rst_n pulled low while in WAIT → mem_req=0, rsp_valid=0, req_ready=1 immediately; rvalid after release is ignored, no rsp_valid.
- LSU_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, gnt never asserted → mem_req drops after 16 cycles, rsp_err=1; next LW completes normally.

Source files
------------

// File: rtl/rv32i_opcodes.sv
// Shared RV32I definitions used by the execute/memory path: funct3 encodings,
// the LSU state type and the register-file load record.
package rv32i_opcodes;

    typedef enum logic [2:0] {
        F3_LB  = 3'd0,
        F3_LH  = 3'd1,
        F3_LW  = 3'd2,
        F3_LBU = 3'd4,
        F3_LHU = 3'd5
    } mem_funct3_t;

    // Stores share the low encodings with the signed loads
    localparam mem_funct3_t F3_SB = F3_LB;
    localparam mem_funct3_t F3_SH = F3_LH;
    localparam mem_funct3_t F3_SW = F3_LW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } lsu_state_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } regfile_load_t;

    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        return we ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3[2:1] == 2'b11));
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data lane select and sign/zero extension; shared by the
// LSU and any future cache read path.
module load_extend
    import rv32i_opcodes::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  mem_funct3_t funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  data = {24'h0, shifted[7:0]};
            F3_LHU:  data = {16'h0, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit driving a req/gnt/rvalid data memory.
// Optional bus timeout in REQ/WAIT is enabled by defining LSU_BUS_TIMEOUT_EN.
module load_store_unit
    import rv32i_opcodes::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [WIDTH-1:0]   req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               rsp_valid,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic               rsp_err,
    output logic               mem_req,
    output logic               mem_we,
    output logic [WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic [WIDTH/8-1:0] mem_be,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [WIDTH-1:0]   mem_rdata
);

    if (WIDTH != 32) begin : g_width_chk
        $error("load_store_unit supports WIDTH=32 only");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
        $error("load_store_unit needs TIMEOUT_CYCLES >= 1");
    end

    lsu_state_t         state, state_nxt;
    logic [WIDTH-1:0]   addr_q, wdata_q, rdata_q;
    logic [WIDTH/8-1:0] be_q;
    logic [2:0]         funct3_q;
    logic               we_q, err_q;
    logic               accept, req_bad, timeout;
    logic [WIDTH-1:0]   st_wdata, ext_data;
    logic [WIDTH/8-1:0] st_be;

    load_extend u_load_extend (
        .rdata   (mem_rdata),
        .addr_lo (addr_q[1:0]),
        .funct3  (mem_funct3_t'(funct3_q)),
        .data    (ext_data)
    );

    always_comb begin
        accept  = req_valid && (state == S_IDLE);
        req_bad = funct3_illegal(req_we, req_funct3)
               || ((req_funct3[1:0] == 2'b01) && req_addr[0])
               || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    // Store data is replicated across lanes so the byte enables alone pick the target
    always_comb begin
        st_wdata = '0;
        st_be    = 4'b1111;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    st_wdata = {4{req_wdata[7:0]}};
                    st_be    = 4'b0001 << req_addr[1:0];
                end
                2'b01: begin
                    st_wdata = {2{req_wdata[15:0]}};
                    st_be    = 4'b0011 << req_addr[1:0];
                end
                default: st_wdata = req_wdata;
            endcase
        end
    end

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;
    logic          in_bus, bus_entry;

    assign in_bus    = (state == S_REQ) || (state == S_WAIT);
    assign bus_entry = (state_nxt != state) && ((state_nxt == S_REQ) || (state_nxt == S_WAIT));
    assign timeout   = in_bus && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         tmo_cnt <= '0;
        else if (bus_entry) tmo_cnt <= '0;
        else if (in_bus)    tmo_cnt <= tmo_cnt + CW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = req_bad ? S_RESP : S_REQ;
            S_REQ: begin
                if (mem_gnt)      state_nxt = we_q ? S_RESP : S_WAIT;
                else if (timeout) state_nxt = S_RESP;
            end
            S_WAIT: if (mem_rvalid || timeout) state_nxt = S_RESP;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (accept && req_bad) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else if (accept) begin
                        addr_q   <= req_addr;
                        funct3_q <= req_funct3;
                        we_q     <= req_we;
                        wdata_q  <= st_wdata;
                        be_q     <= st_be;
                    end
                end
                S_REQ: begin
                    if (mem_gnt && we_q) begin
                        err_q   <= 1'b0;
                        rdata_q <= '0;
                    end else if (!mem_gnt && timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        err_q   <= 1'b0;
                        rdata_q <= ext_data;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_req   = (state == S_REQ);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = {addr_q[WIDTH-1:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions compared against an arithmetic reference model.
module tb_load_store_unit;

`ifdef LSU_BUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          reqcnt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        bit          stable;
        bit          done;
        logic        ready0;
        logic        valid0;
    } txn_t;

    // Reference: expected outcome of one transaction from the architectural rules
    function automatic txn_t model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                   input bit [31:0] wdata, input bit [31:0] rdata,
                                   input int gd, input int rd);
        txn_t e;
        int   a, b, h;
        bit   illegal, mis;
        a       = int'(addr[1:0]);
        illegal = we ? (f3 > 2) : (f3 == 3 || f3 >= 6);
        mis     = ((f3 == 1 || f3 == 5) && (a % 2 == 1)) || (f3 == 2 && a != 0);
        e.err = illegal || mis; e.rdata = 0; e.reqcnt = 0; e.stable = 1; e.done = 1;
        e.ready0 = 1; e.valid0 = 0;
        e.addr = addr - a; e.we = we; e.be = 4'hF; e.wdata = 0;
        if (e.err) begin e.lat = 1; return e; end
        if (TMO_EN && gd >= TMO) begin
            e.lat = 1 + TMO; e.reqcnt = TMO; e.err = 1; return e;
        end
        e.reqcnt = gd + 1;
        if (we) begin
            if (f3 == 0) begin e.be = 4'(1 << a); e.wdata = (wdata % 256) * 32'h0101_0101; end
            else if (f3 == 1) begin e.be = 4'(3 << a); e.wdata = (wdata % 65536) * 32'h0001_0001; end
            else e.wdata = wdata;
            e.lat = gd + 2;
            return e;
        end
        if (TMO_EN && rd >= TMO) begin e.lat = gd + 2 + TMO; e.err = 1; return e; end
        e.lat = gd + 3 + rd;
        b = int'((rdata >> (8 * a)) % 256);
        h = int'((rdata >> (8 * a)) % 65536);
        case (f3)
            3'd0: e.rdata = (b >= 128) ? b - 256 : b;
            3'd1: e.rdata = (h >= 32768) ? h - 65536 : h;
            3'd4: e.rdata = b;
            3'd5: e.rdata = h;
            default: e.rdata = rdata;
        endcase
        return e;
    endfunction

    // Issues one request and plays the memory side; gnt after gd waiting cycles,
    // rvalid after rd cycles in WAIT. junk toggles rvalid while the request is pending.
    task automatic drive_txn(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                             input bit [31:0] wdata, input bit [31:0] rdata,
                             input int gd, input int rd, input bit junk, output txn_t o);
        bit granted = 0;
        int wcnt = 0;
        o.lat = -1; o.rdata = 'x; o.err = 'x; o.reqcnt = 0; o.stable = 1; o.done = 0;
        o.addr = 'x; o.wdata = 'x; o.be = 'x; o.we = 'x;
        @(negedge clk);
        o.ready0 = req_ready; o.valid0 = rsp_valid;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 0; req_wdata = $urandom; req_addr = $urandom; req_funct3 = 3'($urandom);
        for (int c = 1; c <= 80; c++) begin
            if (rsp_valid) begin
                o.lat = c; o.rdata = rsp_rdata; o.err = rsp_err; o.done = 1;
                mem_gnt = 0; mem_rvalid = 0;
                break;
            end
            mem_rvalid = 0;
            mem_rdata  = junk ? $urandom : 32'h0;
            if (granted && !we) begin
                wcnt++;
                if (wcnt > rd) begin mem_rvalid = 1; mem_rdata = rdata; end
            end else if (junk && !granted) begin
                mem_rvalid = 1'($urandom_range(0, 1));
            end
            mem_gnt = 0;
            if (mem_req) begin
                o.reqcnt++;
                if (o.reqcnt == 1) begin
                    o.addr = mem_addr; o.wdata = mem_wdata; o.be = mem_be; o.we = mem_we;
                end else if (o.addr !== mem_addr || o.wdata !== mem_wdata ||
                             o.be !== mem_be || o.we !== mem_we) begin
                    o.stable = 0;
                end
                if (o.reqcnt > gd) begin mem_gnt = 1; granted = 1; end
            end
            @(negedge clk);
        end
        mem_gnt = 0; mem_rvalid = 0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h expected 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
            errors++; $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h be=%h expected all 0",
                               mem_req, mem_we, mem_addr, mem_wdata, mem_be); end
        @(negedge clk); @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_load_byte();
        txn_t o;
        drive_txn(0, 3'd0, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0, 0, o);
        checks++; if (o.lat !== 3) begin errors++; $display("FAIL lb_latency: got %0d expected 3", o.lat); end
        checks++; if (o.rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h expected ffffff80", o.rdata); end
        checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL lb_err: got %b expected 0", o.err); end
    endtask

    task automatic test_load_half();
        txn_t o;
        drive_txn(0, 3'd5, 32'h2002, 32'h0, 32'h9ABC_0000, 0, 0, 0, o);
        checks++; if (o.rdata !== 32'h0000_9ABC) begin errors++; $display("FAIL lhu_rdata: got %h expected 00009abc", o.rdata); end
        checks++; if (o.addr !== 32'h2000 || o.be !== 4'hF || o.we !== 1'b0 || o.wdata !== 32'h0) begin
            errors++; $display("FAIL lhu_mem: got addr=%h be=%h we=%b wdata=%h expected 2000/f/0/0", o.addr, o.be, o.we, o.wdata); end
    endtask

    task automatic test_store_delayed();
        txn_t o;
        drive_txn(1, 3'd0, 32'h3001, 32'h1234_56A5, 32'h0, 3, 0, 0, o);
        checks++; if (o.reqcnt !== 4 || o.stable !== 1'b1) begin
            errors++; $display("FAIL sb_req: got cycles=%0d stable=%b expected 4/1", o.reqcnt, o.stable); end
        checks++; if (o.wdata !== 32'hA5A5_A5A5 || o.be !== 4'b0010 || o.we !== 1'b1 || o.addr !== 32'h3000) begin
            errors++; $display("FAIL sb_mem: got wdata=%h be=%h we=%b addr=%h expected a5a5a5a5/2/1/3000", o.wdata, o.be, o.we, o.addr); end
        checks++; if (o.lat !== 5 || o.err !== 1'b0 || o.rdata !== 32'h0) begin
            errors++; $display("FAIL sb_rsp: got lat=%0d err=%b rdata=%h expected 5/0/0", o.lat, o.err, o.rdata); end
    endtask

    task automatic test_errors();
        txn_t o;
        drive_txn(0, 3'd2, 32'h4002, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, o);
        checks++; if (o.lat !== 1 || o.err !== 1'b1 || o.reqcnt !== 0 || o.rdata !== 32'h0) begin
            errors++; $display("FAIL lw_misaligned: got lat=%0d err=%b reqs=%0d rdata=%h expected 1/1/0/0", o.lat, o.err, o.reqcnt, o.rdata); end
        drive_txn(0, 3'd3, 32'h4000, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, o);
        checks++; if (o.lat !== 1 || o.err !== 1'b1 || o.reqcnt !== 0) begin
            errors++; $display("FAIL ld_illegal: got lat=%0d err=%b reqs=%0d expected 1/1/0", o.lat, o.err, o.reqcnt); end
        drive_txn(1, 3'd1, 32'h4001, 32'hFFFF, 32'h0, 0, 0, 0, o);
        checks++; if (o.lat !== 1 || o.err !== 1'b1 || o.reqcnt !== 0) begin
            errors++; $display("FAIL sh_misaligned: got lat=%0d err=%b reqs=%0d expected 1/1/0", o.lat, o.err, o.reqcnt); end
        drive_txn(1, 3'd4, 32'h4000, 32'hFFFF, 32'h0, 0, 0, 0, o);
        checks++; if (o.lat !== 1 || o.err !== 1'b1 || o.reqcnt !== 0) begin
            errors++; $display("FAIL st_illegal: got lat=%0d err=%b reqs=%0d expected 1/1/0", o.lat, o.err, o.reqcnt); end
    endtask

    task automatic test_reset_midflight();
        bit seen = 0;
        // Reset while REQ is pending: mem_req must drop without a clock edge
        @(negedge clk);
        req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h5000;
        @(negedge clk);
        req_valid = 0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_req_pre: got %b expected 1", mem_req); end
        #2 rst_n = 0; #1;
        checks++; if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_in_req: got mem_req=%b ready=%b expected 0/1", mem_req, req_ready); end
        @(negedge clk); rst_n = 1;
        // Reset while in WAIT
        @(negedge clk);
        req_valid = 1; req_funct3 = 3'd2; req_addr = 32'h5004;
        @(negedge clk);
        req_valid = 0; mem_gnt = mem_req;
        @(negedge clk);
        mem_gnt = 0;
        #2 rst_n = 0; #1;
        checks++; if (mem_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_in_wait: got mem_req=%b rsp_valid=%b ready=%b expected 0/0/1", mem_req, rsp_valid, req_ready); end
        @(negedge clk); rst_n = 1;
        mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) mem_rvalid = 0;
            if (rsp_valid) seen = 1;
        end
        checks++; if (seen !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_late_rvalid: got rsp_seen=%b ready=%b expected 0/1", seen, req_ready); end
    endtask

    task automatic test_long_grant();
        txn_t o, e;
        e = model(0, 3'd2, 32'h6000, 32'h0, 32'hCAFE_F00D, 20, 0);
        drive_txn(0, 3'd2, 32'h6000, 32'h0, 32'hCAFE_F00D, 20, 0, 0, o);
        checks++; if (o.lat !== e.lat || o.err !== e.err || o.reqcnt !== e.reqcnt || o.rdata !== e.rdata) begin
            errors++; $display("FAIL long_grant: got lat=%0d err=%b reqs=%0d rdata=%h expected %0d/%b/%0d/%h",
                               o.lat, o.err, o.reqcnt, o.rdata, e.lat, e.err, e.reqcnt, e.rdata); end
        e = model(0, 3'd2, 32'h6008, 32'h0, 32'h0BAD_F00D, 0, 0);
        drive_txn(0, 3'd2, 32'h6008, 32'h0, 32'h0BAD_F00D, 0, 0, 0, o);
        checks++; if (o.lat !== e.lat || o.err !== e.err || o.rdata !== e.rdata || o.ready0 !== 1'b1) begin
            errors++; $display("FAIL after_long: got lat=%0d err=%b rdata=%h ready=%b expected %0d/%b/%h/1",
                               o.lat, o.err, o.rdata, o.ready0, e.lat, e.err, e.rdata); end
    endtask

    task automatic test_random();
        txn_t o, e;
        for (int n = 0; n < 60; n++) begin
            bit          we    = 1'($urandom_range(0, 1));
            bit [2:0]    f3    = (n % 4 == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)) | (we ? 3'd0 : 3'($urandom_range(0, 1) * 4));
            bit [31:0]   addr  = $urandom;
            bit [31:0]   wdata = $urandom;
            bit [31:0]   rdata = $urandom;
            int          gd    = $urandom_range(0, 3);
            int          rd    = $urandom_range(0, 3);
            if (n % 2 == 0 && f3 != 3'd0 && f3 != 3'd4) addr[0] = 0;
            if (n % 3 == 0 && f3[1:0] == 2'd2) addr[1:0] = 0;
            e = model(we, f3, addr, wdata, rdata, gd, rd);
            drive_txn(we, f3, addr, wdata, rdata, gd, rd, 1, o);
            checks++; if (o.ready0 !== 1'b1 || o.valid0 !== 1'b0) begin
                errors++; $display("FAIL rand_idle[%0d]: got ready=%b rsp_valid=%b expected 1/0", n, o.ready0, o.valid0); end
            checks++; if (o.done !== 1'b1 || o.lat !== e.lat) begin
                errors++; $display("FAIL rand_latency[%0d]: got done=%b lat=%0d expected 1/%0d", n, o.done, o.lat, e.lat); end
            checks++; if (o.err !== e.err || o.rdata !== e.rdata) begin
                errors++; $display("FAIL rand_rsp[%0d] we=%b f3=%0d addr=%h: got err=%b rdata=%h expected %b/%h",
                                   n, we, f3, addr, o.err, o.rdata, e.err, e.rdata); end
            checks++; if (o.reqcnt !== e.reqcnt) begin
                errors++; $display("FAIL rand_reqcnt[%0d]: got %0d expected %0d", n, o.reqcnt, e.reqcnt); end
            if (e.reqcnt > 0) begin
                checks++; if (o.addr !== e.addr || o.be !== e.be || o.wdata !== e.wdata || o.we !== e.we || o.stable !== 1'b1) begin
                    errors++; $display("FAIL rand_mem[%0d] f3=%0d: got addr=%h be=%h wdata=%h we=%b stable=%b expected %h/%h/%h/%b/1",
                                       n, f3, o.addr, o.be, o.wdata, o.we, o.stable, e.addr, e.be, e.wdata, e.we); end
            end
        end
    endtask

    task automatic test_timeout();
        txn_t o, e;
        e = model(0, 3'd2, 32'h7000, 32'h0, 32'h0, 100, 0);
        drive_txn(0, 3'd2, 32'h7000, 32'h0, 32'h0, 100, 0, 0, o);
        checks++; if (o.reqcnt !== TMO || o.err !== 1'b1 || o.rdata !== 32'h0 || o.lat !== e.lat) begin
            errors++; $display("FAIL tmo_gnt: got reqs=%0d err=%b rdata=%h lat=%0d expected %0d/1/0/%0d",
                               o.reqcnt, o.err, o.rdata, o.lat, TMO, e.lat); end
        e = model(0, 3'd4, 32'h7001, 32'h0, 32'h1234_5678, 0, 40);
        drive_txn(0, 3'd4, 32'h7001, 32'h0, 32'h1234_5678, 0, 40, 0, o);
        checks++; if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.lat !== e.lat) begin
            errors++; $display("FAIL tmo_rvalid: got err=%b rdata=%h lat=%0d expected 1/0/%0d", o.err, o.rdata, o.lat, e.lat); end
        mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        e = model(0, 3'd2, 32'h7008, 32'h0, 32'hA5A5_0F0F, 0, 0);
        drive_txn(0, 3'd2, 32'h7008, 32'h0, 32'hA5A5_0F0F, 0, 0, 0, o);
        checks++; if (o.err !== 1'b0 || o.rdata !== 32'hA5A5_0F0F || o.lat !== 3) begin
            errors++; $display("FAIL tmo_recover: got err=%b rdata=%h lat=%0d expected 0/a5a50f0f/3", o.err, o.rdata, o.lat); end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half();
        test_store_delayed();
        test_errors();
        test_reset_midflight();
        test_long_grant();
        test_random();
        if (TMO_EN) test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
